// File: rtl/ram8b_pkg.sv
// Shared parameters, address decode type and helper for the ram8b register file.
// The address is split into a bank select (MSB) and a word index (low IDX_W bits).
package ram8b_pkg;

    localparam int ADDR_W     = 33;
    localparam int DATA_W     = 16;
    localparam int BANK_DEPTH = 8;
    localparam int IDX_W      = $clog2(BANK_DEPTH);

    typedef struct packed {
        logic             bank;
        logic [IDX_W-1:0] idx;
    } word_sel_t;

    // Middle address bits alias: they fold into the same word.
    function automatic word_sel_t decode(input logic [ADDR_W-1:0] addr);
        word_sel_t sel;
        logic      unused_mid;
        unused_mid = ^addr[ADDR_W-2:IDX_W];
        sel.bank   = addr[ADDR_W-1];
        sel.idx    = addr[IDX_W-1:0];
        return sel;
    endfunction

endpackage

// File: rtl/ram8b_bank.sv
// One bank: BANK_DEPTH x DATA_W register file, async active-low clear,
// one synchronous write port (we, wr_idx, d_in), two combinational reads.
module ram8b_bank
    import ram8b_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] d_in,
    input  logic [IDX_W-1:0]  rd_idx_a,
    input  logic [IDX_W-1:0]  rd_idx_b,
    output logic [DATA_W-1:0] d_out_a,
    output logic [DATA_W-1:0] d_out_b
);

    logic [DATA_W-1:0] mem [BANK_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_idx] <= d_in;
        end
    end

    // No bypass: a read of the word being written shows old data until the edge.
    assign d_out_a = mem[rd_idx_a];
    assign d_out_b = mem[rd_idx_b];

endmodule

// File: rtl/ram8b.sv
// Dual-read, single-write 16-word register-file RAM built from two banks.
// Ports: clk, reset (async active-low), wr/wr_addr/d_in write port,
// rd_addr_a/d_out_a and rd_addr_b/d_out_b combinational read ports.
module ram8b
    import ram8b_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out_a,
    output logic [DATA_W-1:0] d_out_b
);

    word_sel_t wsel;
    word_sel_t asel;
    word_sel_t bsel;

    assign wsel = decode(wr_addr);
    assign asel = decode(rd_addr_a);
    assign bsel = decode(rd_addr_b);

    logic [1:0]        we;
    logic [DATA_W-1:0] out_a [2];
    logic [DATA_W-1:0] out_b [2];

    assign we[0] = wr & ~wsel.bank;
    assign we[1] = wr &  wsel.bank;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        ram8b_bank u_bank (
            .clk      (clk),
            .reset    (reset),
            .we       (we[g]),
            .wr_idx   (wsel.idx),
            .d_in     (d_in),
            .rd_idx_a (asel.idx),
            .rd_idx_b (bsel.idx),
            .d_out_a  (out_a[g]),
            .d_out_b  (out_b[g])
        );
    end

    assign d_out_a = asel.bank ? out_a[1] : out_a[0];
    assign d_out_b = bsel.bank ? out_b[1] : out_b[0];

endmodule

// File: tb/tb_ram8b.sv
// Self-checking bench for ram8b: directed scenarios with literal expectations
// plus randomized traffic compared each cycle against a word-array model.
module tb_ram8b;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr = 1'b0;
    logic [32:0] wr_addr = '0;
    logic [32:0] rd_addr_a = '0;
    logic [32:0] rd_addr_b = '0;
    logic [15:0] d_in = '0;
    logic [15:0] d_out_a;
    logic [15:0] d_out_b;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // 16 words flattened: word number = bank * 8 + (addr mod 8)
    logic [15:0] model [16];

    ram8b dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .d_in      (d_in),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b)
    );

    always #5 clk = ~clk;

    function automatic int word_of(input logic [32:0] a);
        longint unsigned v;
        v = longint'(a);
        return int'((v / 64'h1_0000_0000) * 8 + (v % 8));
    endfunction

    function automatic logic [15:0] model_rd(input logic [32:0] a);
        return model[word_of(a)];
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask

    // Drive a write, let it commit on the next edge, update the model there.
    task automatic do_write(input logic [32:0] a, input logic [15:0] d);
        wr = 1'b1;
        wr_addr = a;
        d_in = d;
        @(posedge clk);
        if (reset) model[word_of(a)] = d;
        #1;
        wr = 1'b0;
    endtask

    task automatic read_all_zero(input string name);
        logic [32:0] a;
        cmp_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a = {i[3], 29'd0, i[2:0]};
            rd_addr_a = a;
            rd_addr_b = a;
            #1;
            check({name, "_a"}, d_out_a, 16'h0000);
            check({name, "_b"}, d_out_b, 16'h0000);
        end
        cmp_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_a", d_out_a, model_rd(rd_addr_a));
            check("cmp_b", d_out_b, model_rd(rd_addr_b));
        end
    end

    initial begin
        logic [32:0] a;
        logic [15:0] d;

        clear_model();
        // 1. reset
        #2 reset = 1'b0;
        #1;
        check("reset_a", d_out_a, 16'h0000);
        check("reset_b", d_out_b, 16'h0000);
        #9 reset = 1'b1;
        read_all_zero("reset_read");
        cmp_en = 1'b1;

        // 2. basic write/read
        @(posedge clk); #1;
        do_write(33'h0_0000_0000, 16'hABCD);
        do_write(33'h0_0000_0001, 16'h1234);
        rd_addr_a = 33'h0_0000_0000;
        rd_addr_b = 33'h0_0000_0001;
        #1;
        check("basic_a", d_out_a, 16'hABCD);
        check("basic_b", d_out_b, 16'h1234);

        // 3. bank isolation
        do_write(33'h1_0000_0000, 16'h5678);
        rd_addr_a = 33'h1_0000_0000;
        rd_addr_b = 33'h0_0000_0000;
        #1;
        check("bank1_a", d_out_a, 16'h5678);
        check("bank0_b", d_out_b, 16'hABCD);

        // 4. aliasing through ignored middle bits
        do_write(33'h0_0000_0108, 16'hBEEF);
        rd_addr_a = 33'h0_0000_0000;
        rd_addr_b = 33'h1_0000_0000;
        #1;
        check("alias_a", d_out_a, 16'hBEEF);
        check("alias_b", d_out_b, 16'h5678);

        // 5. read-during-write
        do_write(33'h0_0000_0003, 16'h1111);
        rd_addr_a = 33'h0_0000_0003;
        wr = 1'b1;
        wr_addr = 33'h0_0000_0003;
        d_in = 16'h2222;
        #1;
        check("rdw_before", d_out_a, 16'h1111);
        @(posedge clk);
        if (reset) model[3] = 16'h2222;
        #1;
        check("rdw_after", d_out_a, 16'h2222);
        wr = 1'b0;
        @(posedge clk); #1;
        check("rdw_hold", d_out_a, 16'h2222);

        // randomized traffic, checked by the negedge compare process
        for (int n = 0; n < 300; n++) begin
            rd_addr_a = {1'($urandom), 32'($urandom)};
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a
                      : {1'($urandom), 32'($urandom)};
            if ($urandom_range(0, 2) != 0) begin
                a = {1'($urandom), 32'($urandom)};
                if ($urandom_range(0, 3) == 0) rd_addr_a = a;
                do_write(a, 16'($urandom));
            end else begin
                @(posedge clk); #1;
            end
        end

        // 6. reset mid-operation: fill all words first
        for (int i = 0; i < 16; i++) begin
            a = {i[3], 29'd0, i[2:0]};
            do_write(a, 16'($urandom) | 16'h0001);
        end
        a = {1'b1, 29'd0, 3'd5};
        rd_addr_a = a;
        rd_addr_b = 33'h0_0000_0002;
        #1;
        check("filled_a", d_out_a, model_rd(a));
        wr = 1'b1;
        wr_addr = a;
        d_in = 16'hCAFE;
        #2;
        reset = 1'b0;
        clear_model();
        #1;
        check("midrst_a", d_out_a, 16'h0000);
        check("midrst_b", d_out_b, 16'h0000);
        @(posedge clk); #1;
        check("midrst_nowr", d_out_a, 16'h0000);
        wr = 1'b0;
        #1 reset = 1'b1;
        read_all_zero("post_rst");

        // writes resume after release
        do_write(a, 16'h0F0F);
        rd_addr_a = a;
        #1;
        check("resume", d_out_a, 16'h0F0F);
        @(posedge clk); #1;

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
